stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Mode controller for the stopwatch. Consumes debounced button levels, detects
//   presses and long-holds, and runs the IDLE/RUNNING/PAUSED/LAP state machine.
//   Drives run-enable, display-freeze and clear/lap strobes to the time counter
//   and display path. Sits between the debouncers and the counting datapath.
// PARAMETERS
//   LONG_PRESS_TICKS  2000  tick count btn_clear must be held to issue a clear
//                           (2 s at 1 kHz tick); legal range >= 1
// PORTS
//   clk           in   1  board clock
//   rst           in   1  asynchronous, active-low reset
//   tick          in   1  1-cycle sample strobe, 1 kHz, from a Clock_Hz instance
//   btn_start     in   1  debounced start/stop level, 1 = pressed
//   btn_lap       in   1  debounced lap level, 1 = pressed
//   btn_clear     in   1  debounced clear level, 1 = pressed
//   run           out  1  1 = time counter advances
//   freeze        out  1  1 = display holds its captured lap value
//   lap_pulse     out  1  1-cycle strobe: capture current time into lap register
//   clear_pulse   out  1  1-cycle strobe: zero the time counter
//   state         out  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 LAP
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE; run, freeze, lap_pulse, clear_pulse = 0;
//     previous-level registers = 1, so a button held through reset does not fire.
//   - Press = level 1 this cycle AND 0 in the previous cycle, per button, every clk.
//     State and all outputs update on the same clk edge that sees the press.
//   - Transitions (all others hold):
//     IDLE:    start -> RUNNING
//     RUNNING: start -> PAUSED;  lap -> LAP, lap_pulse=1 for that cycle
//     LAP:     lap -> RUNNING (new lap_pulse=1);  start -> PAUSED
//     PAUSED:  start -> RUNNING;  long-clear -> IDLE, clear_pulse=1 for that cycle
//   - Decode: run=1 in RUNNING|LAP; freeze=1 only in LAP.
//   - Simultaneous start and lap press: start wins, lap is dropped.
//   - Long-clear: hold counter, width $clog2(LONG_PRESS_TICKS+1). It increments on
//     tick while btn_clear=1 and saturates at LONG_PRESS_TICKS. It clears to 0 on
//     the clk where btn_clear=0. Long-clear fires on the single clk where the
//     counter reaches LONG_PRESS_TICKS, so one hold issues exactly one event.
//   - Long-clear is honoured only in PAUSED. In IDLE/RUNNING/LAP the counter still
//     counts but the event is discarded. A hold begun in RUNNING that saturates
//     before PAUSED is entered does not fire.
//   - Clear wins over start if both events occur in the same PAUSED cycle.
//   - Mid-operation reset returns to IDLE at once; strobes are never stretched.
// CONFIGURATION
//   STOPWATCH_CTRL_LAP_EN defined: lap handling as above.
//   Not defined: btn_lap ignored; LAP unreachable; freeze and lap_pulse tied 0;
//   RUNNING responds only to start.
// TESTING
//   1 rst low with btn_start=1, release rst, hold btn_start -> state stays 00, run=0.
//   2 Pulse btn_start 3 times -> state 01, 10, 01; run 1, 0, 1 on the press edge.
//   3 RUNNING, press lap -> state=11, freeze=1, lap_pulse high exactly 1 clk; press
//     lap again -> state=01, freeze=0, second 1-clk lap_pulse.
//   4 PAUSED, hold btn_clear for 1999 ticks -> no clear_pulse. Hold to tick 2000 ->
//     one clear_pulse, state=00. Keep holding 500 more ticks -> no further pulse.
//   5 RUNNING, btn_start and btn_lap rise same clk -> state=10, lap_pulse stays 0.
//   6 Without STOPWATCH_CTRL_LAP_EN: RUNNING, press lap -> state=01, freeze=0,
//     lap_pulse=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: button press / long-hold detection and the
// IDLE/RUNNING/PAUSED/LAP state machine. Lap handling under `STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl #(
    parameter int LONG_PRESS_TICKS = 2000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       btn_start_i,
    input  logic       btn_lap_i,
    input  logic       btn_clear_i,
    output logic       run_o,
    output logic       freeze_o,
    output logic       lap_pulse_o,
    output logic       clear_pulse_o,
    output logic [1:0] state_o
);
    localparam int CW = $clog2(LONG_PRESS_TICKS + 1);
    localparam logic [CW-1:0] HOLD_MAX  = CW'(LONG_PRESS_TICKS);
    localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_PRESS_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        LAP     = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic          run_q, freeze_q, lap_pulse_q, clear_pulse_q;
    logic          lap_pulse_d, clear_pulse_d;
    logic          start_prev_q, clear_prev_q;
    logic [CW-1:0] hold_q, hold_d;
    logic          start_press, lap_press, long_clear;

    // Previous levels reset to 1 so a button held through reset never reads as a press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_prev_q <= 1'b1;
            clear_prev_q <= 1'b1;
        end else begin
            start_prev_q <= btn_start_i;
            clear_prev_q <= btn_clear_i;
        end
    end

    assign start_press = btn_start_i & ~start_prev_q;

`ifdef STOPWATCH_CTRL_LAP_EN
    logic lap_prev_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lap_prev_q <= 1'b1;
        else         lap_prev_q <= btn_lap_i;
    end
    assign lap_press = btn_lap_i & ~lap_prev_q;
`else
    logic unused_lap;
    assign unused_lap = btn_lap_i;
    assign lap_press  = 1'b0;
`endif

    // Hold counter saturates, so the reach-max moment happens once per hold.
    always_comb begin
        hold_d = hold_q;
        if (!btn_clear_i)
            hold_d = '0;
        else if (tick_i && hold_q != HOLD_MAX)
            hold_d = hold_q + 1'b1;
    end

    assign long_clear = btn_clear_i & tick_i & (hold_q == HOLD_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) hold_q <= '0;
        else         hold_q <= hold_d;
    end

    always_comb begin
        state_d       = state_q;
        lap_pulse_d   = 1'b0;
        clear_pulse_d = 1'b0;
        case (state_q)
            IDLE:    if (start_press) state_d = RUNNING;
            RUNNING: begin
                if (start_press) state_d = PAUSED;
                else if (lap_press) begin
                    state_d     = LAP;
                    lap_pulse_d = 1'b1;
                end
            end
            LAP: begin
                if (start_press) state_d = PAUSED;
                else if (lap_press) begin
                    state_d     = RUNNING;
                    lap_pulse_d = 1'b1;
                end
            end
            PAUSED: begin
                if (long_clear) begin
                    state_d       = IDLE;
                    clear_pulse_d = 1'b1;
                end else if (start_press) state_d = RUNNING;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            run_q         <= 1'b0;
            freeze_q      <= 1'b0;
            lap_pulse_q   <= 1'b0;
            clear_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_q         <= (state_d == RUNNING) || (state_d == LAP);
            freeze_q      <= (state_d == LAP);
            lap_pulse_q   <= lap_pulse_d;
            clear_pulse_q <= clear_pulse_d;
        end
    end

    assign run_o         = run_q;
    assign clear_pulse_o = clear_pulse_q;
    assign state_o       = state_q;
`ifdef STOPWATCH_CTRL_LAP_EN
    assign freeze_o    = freeze_q;
    assign lap_pulse_o = lap_pulse_q;
`else
    logic unused_lapq;
    assign unused_lapq = freeze_q | lap_pulse_q;
    assign freeze_o    = 1'b0;
    assign lap_pulse_o = 1'b0;
`endif

endmodule
